// File: rtl/instr_loader.sv
// instr_loader: boot-time writer for the DSP instruction memory.
//
// A host streams one framed load over a byte-wide valid/ready handshake:
//   count hi, count lo (N), N words sent hi byte then lo byte, and a checksum byte
//   equal to the XOR of every preceding byte of the frame.
// Each assembled 16-bit word is written to instruction memory at address 2*index,
// which matches the PC's +2 stride. The DSP core is held in reset until a frame
// loads completely and its checksum verifies.
//
// Ports:
//   clk_i          system clock, rising edge
//   reset_i        asynchronous, active-high reset
//   start_i        single-cycle pulse; begins a load from idle, done or error
//   in_valid_i     byte on in_data_i is valid
//   in_data_i      stream byte
//   in_ready_o     loader can accept a byte this cycle
//   imem_wr_en_o   instruction memory write strobe, one cycle per word
//   imem_addr_o    write address, always even
//   imem_data_o    write data
//   dsp_reset_o    high holds the DSP core in reset
//   busy_o         load in progress
//   done_o         last load succeeded (level)
//   error_o        last load failed (level)
module instr_loader #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned MAX_WORDS  = 2048
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  in_valid_i,
  input  logic [7:0]            in_data_i,
  output logic                  in_ready_o,
  output logic                  imem_wr_en_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  output logic [WORD_WIDTH-1:0] imem_data_o,
  output logic                  dsp_reset_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

  // One extra bit so a count of 0xFFFF cannot alias below the limit.
  localparam logic [16:0] MaxWords = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    StIdle,
    StCntHi,
    StCntLo,
    StDataHi,
    StDataLo,
    StCheck,
    StDone,
    StErr
  } state_e;

  state_e state_q, state_d;

  logic [15:0]           cnt_q, cnt_d;
  logic [15:0]           idx_q, idx_d;
  logic [7:0]            word_hi_q, word_hi_d;
  logic [7:0]            csum_q, csum_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;

  logic        accept;
  logic        start_load;
  logic [15:0] cnt_full;

  // in_ready_o is a pure function of state, so accept can only fire in load states.
  assign accept     = in_valid_i && in_ready_o;
  // start is honoured only when no load is running.
  assign start_load = start_i && (state_q == StIdle || state_q == StDone || state_q == StErr);
  // Full word count as it becomes known in the cycle the low byte is accepted.
  assign cnt_full   = {cnt_q[15:8], in_data_i};

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start_i) state_d = StCntHi;
      end
      StCntHi: begin
        if (accept) state_d = StCntLo;
      end
      StCntLo: begin
        if (accept) begin
          if ({1'b0, cnt_full} > MaxWords) begin
            state_d = StErr;
          end else if (cnt_full == 16'd0) begin
            state_d = StCheck;
          end else begin
            state_d = StDataHi;
          end
        end
      end
      StDataHi: begin
        if (accept) state_d = StDataLo;
      end
      StDataLo: begin
        // cnt_q >= 1 here, so cnt_q - 1 cannot underflow.
        if (accept) state_d = (idx_q == cnt_q - 16'd1) ? StCheck : StDataHi;
      end
      StCheck: begin
        if (accept) state_d = (in_data_i == csum_q) ? StDone : StErr;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic.
  always_comb begin
    in_ready_o  = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    error_o     = 1'b0;
    dsp_reset_o = 1'b1;
    unique case (state_q)
      StCntHi, StCntLo, StDataHi, StDataLo, StCheck: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b1;
      end
      StDone: begin
        done_o      = 1'b1;
        dsp_reset_o = 1'b0;
      end
      StErr: begin
        error_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign imem_wr_en_o = wr_en_q;
  assign imem_addr_o  = addr_q;
  assign imem_data_o  = data_q;

  // Datapath next-state: count, word index, running checksum and write port.
  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    word_hi_d = word_hi_q;
    csum_d    = csum_q;
    wr_en_d   = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;

    if (start_load) begin
      csum_d = 8'h00;
      idx_d  = 16'd0;
    end

    if (accept) begin
      unique case (state_q)
        StCntHi: begin
          cnt_d[15:8] = in_data_i;
          csum_d      = csum_q ^ in_data_i;
        end
        StCntLo: begin
          cnt_d[7:0] = in_data_i;
          csum_d     = csum_q ^ in_data_i;
        end
        StDataHi: begin
          word_hi_d = in_data_i;
          csum_d    = csum_q ^ in_data_i;
        end
        StDataLo: begin
          csum_d  = csum_q ^ in_data_i;
          wr_en_d = 1'b1;
          // Byte address of the word; truncation is the modulo 2^ADDR_WIDTH.
          addr_d  = ADDR_WIDTH'({idx_q, 1'b0});
          data_d  = WORD_WIDTH'({word_hi_q, in_data_i});
          idx_d   = idx_q + 16'd1;
        end
        default: ;  // checksum byte is compared, never folded in
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q     <= 16'd0;
      idx_q     <= 16'd0;
      word_hi_q <= 8'h00;
      csum_q    <= 8'h00;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      word_hi_q <= word_hi_d;
      csum_q    <= csum_d;
      wr_en_q   <= wr_en_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: a frame-level reference model predicts every
// memory write and the load outcome; a negedge monitor compares them as they appear.
module tb_instr_loader;

  localparam int AW   = 12;
  localparam int WW   = 16;
  localparam int MAXW = 2048;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          imem_wr_en;
  logic [AW-1:0] imem_addr;
  logic [WW-1:0] imem_data;
  logic          dsp_reset;
  logic          busy;
  logic          done;
  logic          error;

  instr_loader #(
    .ADDR_WIDTH(AW),
    .WORD_WIDTH(WW),
    .MAX_WORDS (MAXW)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (start),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .imem_wr_en_o(imem_wr_en),
    .imem_addr_o (imem_addr),
    .imem_data_o (imem_data),
    .dsp_reset_o (dsp_reset),
    .busy_o      (busy),
    .done_o      (done),
    .error_o     (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
    int            cyc;
  } wr_t;

  typedef struct {
    logic ok;
    int   cyc;
  } res_t;

  wr_t        wq[$];
  res_t       rq[$];
  logic [7:0] frame[$];
  logic       prev_busy = 1'b0;

  // Monitor: every write strobe and every end of a load is checked against the queues.
  always @(negedge clk) begin
    if (reset) begin
      prev_busy = 1'b0;
    end else begin
      if (imem_wr_en) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=%h data=%h at cyc %0d, required none",
                   imem_addr, imem_data, cyc);
        end else begin
          wr_t e;
          e = wq.pop_front();
          if (imem_addr !== e.addr || imem_data !== e.data || cyc != e.cyc) begin
            errors++;
            $display("FAIL write: got addr=%h data=%h cyc=%0d, required addr=%h data=%h cyc=%0d",
                     imem_addr, imem_data, cyc, e.addr, e.data, e.cyc);
          end
        end
      end
      if (prev_busy && !busy) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_end: load ended at cyc %0d with no frame outstanding", cyc);
        end else begin
          res_t r;
          r = rq.pop_front();
          if (done !== r.ok || error !== !r.ok || dsp_reset !== !r.ok || in_ready !== 1'b0 ||
              cyc != r.cyc) begin
            errors++;
            $display({"FAIL outcome: got done=%b error=%b dsp_reset=%b in_ready=%b cyc=%0d, ",
                      "required done=%b error=%b dsp_reset=%b in_ready=0 cyc=%0d"},
                     done, error, dsp_reset, in_ready, cyc, r.ok, !r.ok, !r.ok, r.cyc);
          end
        end
      end
      prev_busy = busy;
    end
  end

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({in_ready, imem_wr_en, imem_addr, imem_data, dsp_reset, busy, done, error} !==
        {1'b0, 1'b0, {AW{1'b0}}, {WW{1'b0}}, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display({"FAIL %s: got rdy=%b we=%b addr=%h data=%h dsp_rst=%b busy=%b done=%b err=%b, ",
                "required rdy=0 we=0 addr=0 data=0 dsp_rst=1 busy=0 done=0 err=0"},
               name, in_ready, imem_wr_en, imem_addr, imem_data, dsp_reset, busy, done, error);
    end
  endtask

  // Builds a well-formed frame of n words; mode 1 makes each word equal its index.
  task automatic build_frame(input int n, input int mode, input bit corrupt);
    logic [7:0] x;
    logic [15:0] w;
    frame.delete();
    frame.push_back(8'(n >> 8));
    frame.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      w = (mode == 1) ? 16'(i) : 16'($urandom);
      frame.push_back(w[15:8]);
      frame.push_back(w[7:0]);
    end
    x = 8'h00;
    foreach (frame[k]) x ^= frame[k];
    if (corrupt) x ^= 8'(1 << $urandom_range(0, 7));
    frame.push_back(x);
  endtask

  // Drives the frame after a start pulse. Expected writes and outcome are derived
  // from the frame contents: count, word bytes and the XOR of the preceding bytes.
  task automatic run_frame(input int gap_max, input int start_at, input int abort_at);
    int         n_words;
    bit         over;
    int         consumed;
    logic [7:0] x;
    bit         ok;
    n_words  = int'({frame[0], frame[1]});
    over     = n_words > MAXW;
    consumed = over ? 2 : 2 + 2 * n_words + 1;
    x = 8'h00;
    for (int k = 0; k < consumed - 1; k++) x ^= frame[k];
    ok = !over && (frame[consumed-1] == x);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < consumed; k++) begin
      int wait_n;
      int gap;
      gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      if (gap_max == 1) gap = 1;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = frame[k];
      start    = (k == start_at);
      wait_n   = 0;
      while (in_ready !== 1'b1 && wait_n < 64) begin
        @(negedge clk);
        wait_n++;
      end
      if (wait_n >= 64) begin
        checks++;
        errors++;
        $display("FAIL handshake_timeout: byte %0d never accepted, in_ready=%b", k, in_ready);
        in_valid = 1'b0;
        start    = 1'b0;
        return;
      end
      // Accepted at the coming posedge.
      if (!over && k >= 3 && k < 2 + 2 * n_words && (k % 2) == 1) begin
        int i;
        i = (k - 3) / 2;
        wq.push_back('{addr: AW'(2 * i), data: {frame[k-1], frame[k]}, cyc: cyc + 1});
      end
      if (k == consumed - 1) rq.push_back('{ok: ok, cyc: cyc + 1});
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
      if (k == abort_at) begin
        #2 reset = 1'b1;
        #1 check_reset_outputs("async_reset_midload");
        wq.delete();
        rq.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
          errors++;
          $display("FAIL idle_after_reset: got rdy=%b busy=%b done=%b err=%b, required all 0",
                   in_ready, busy, done, error);
        end
        return;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic set_frame(input logic [7:0] b[$]);
    frame = b;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #1 check_reset_outputs("reset_values");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Nominal frame at full rate.
    set_frame('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42});
    run_frame(0, -1, -1);
    // Bad checksum, then the good frame again.
    set_frame('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43});
    run_frame(0, -1, -1);
    set_frame('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42});
    run_frame(0, -1, -1);
    // Zero count.
    set_frame('{8'h00, 8'h00, 8'h00});
    run_frame(0, -1, -1);
    // Oversize count.
    set_frame('{8'h08, 8'h01});
    run_frame(0, -1, -1);
    checks++;
    if (in_ready !== 1'b0 || error !== 1'b1) begin
      errors++;
      $display("FAIL oversize_hold: got in_ready=%b error=%b, required in_ready=0 error=1",
               in_ready, error);
    end
    // Valid toggling every other cycle.
    set_frame('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42});
    run_frame(1, -1, -1);
    // Reset right after the byte 12.
    run_frame(0, -1, 2);
    set_frame('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42});
    run_frame(0, -1, -1);
    // Maximum frame, start pulsed mid-load.
    build_frame(MAXW, 1, 1'b0);
    run_frame(0, 1001, -1);
    // Random frames.
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 9) == 0) begin
        int n;
        n = $urandom_range(MAXW + 1, 65535);
        frame.delete();
        frame.push_back(8'(n >> 8));
        frame.push_back(8'(n));
      end else begin
        build_frame($urandom_range(0, 6), 0, $urandom_range(0, 3) == 0);
      end
      run_frame(2, -1, -1);
    end

    checks++;
    if (wq.size() != 0 || rq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d writes and %0d outcomes outstanding, required 0 and 0",
               wq.size(), rq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Boot-time writer for the DSP instruction memory.
- Accepts a framed byte stream over a valid/ready handshake and assembles 16-bit instruction words.
- Writes each word to instruction memory at even addresses, matching the PC's +2 stride.
- Holds the DSP core in reset until a frame loads and its checksum verifies.
- Sits between the host/boot interface and the instrmem write port, beside the dsp top level.

Parameters:
ADDR_WIDTH, 12, instruction memory address width (matches PC width)
WORD_WIDTH, 16, instruction word width; fixed at 16 for this frame format
MAX_WORDS, 2048, largest accepted word count (2^ADDR_WIDTH / 2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERR
in_valid  input  1  byte on in_data is valid
in_data  input  8  stream byte
in_ready  output  1  loader can accept a byte this cycle
imem_wr_en  output  1  instruction memory write strobe, one cycle per word
imem_addr  output  ADDR_WIDTH  write address, always even
imem_data  output  WORD_WIDTH  write data
dsp_reset  output  1  high holds the DSP core in reset
busy  output  1  load in progress
done  output  1  last load succeeded (level)
error  output  1  last load failed (level)

Behaviour:
- Reset values: in_ready=0, imem_wr_en=0, imem_addr=0, imem_data=0, dsp_reset=1, busy=0, done=0, error=0; state=IDLE.
- Reset is asynchronous and may arrive mid-load. It aborts the load immediately and returns every output to its reset value.
- Frame format, in byte order:
  - count high byte, then count low byte (N);
  - N words, each sent high byte then low byte;
  - one checksum byte equal to the XOR of every preceding byte in the frame.
- A byte is accepted when in_valid && in_ready at a rising clk edge.
- in_ready=1 exactly in states CNT_HI, CNT_LO, DATA_HI, DATA_LO and CHECK.
- States and transitions:
  - IDLE: start -> CNT_HI; clear csum, word index, done and error; busy=1, dsp_reset=1.
  - CNT_HI: accept -> latch N[15:8] -> CNT_LO.
  - CNT_LO: accept -> latch N[7:0]. If N > MAX_WORDS -> ERR. Else if N == 0 -> CHECK. Else -> DATA_HI.
  - DATA_HI: accept -> latch word[15:8] -> DATA_LO.
  - DATA_LO: accept -> latch word[7:0] and schedule a write. If the word index reaches N-1 -> CHECK, else -> DATA_HI.
  - CHECK: accept -> compare the byte with running csum. Match -> DONE; mismatch -> ERR.
  - DONE: done=1, busy=0, dsp_reset=0. start -> CNT_HI path (same as IDLE start).
  - ERR: error=1, busy=0, dsp_reset=1. start -> restart as from IDLE.
- start is ignored while busy=1.
- The running csum is updated with every accepted byte before CHECK. The checksum byte itself is not folded in.
- Write timing:
  - imem_wr_en pulses high for exactly one cycle, in the cycle after the DATA_LO byte is accepted.
  - imem_addr = 2*word_index, computed modulo 2^ADDR_WIDTH; no wrap occurs because N ≤ MAX_WORDS.
  - imem_data = {hi, lo}.
  - imem_addr and imem_data hold their last values between writes.
- Back-to-back bytes are accepted every cycle, giving a peak rate of one word per 2 cycles. No internal stall.
- The last write pulse always completes before the CHECK byte can be accepted, so a DONE state implies all words are written.
- Data words are written to memory before the checksum is verified. A failed frame leaves memory partially or wholly written; dsp_reset stays 1, so the core never runs it.
- dsp_reset deasserts one cycle after the CHECK byte is accepted with a match.

Test Plan:
- Nominal: after reset, pulse start; stream 00 02 12 34 AB CD 42 at full rate -> writes (addr 0x000, data 0x1234) and (addr 0x002, data 0xABCD), one cycle each; done=1, error=0, dsp_reset=0.
- Bad checksum: same frame with last byte 43 -> both writes still occur; error=1, done=0, dsp_reset=1; a new start plus the correct frame then reaches DONE.
- Zero count: start, stream 00 00 00 -> no imem_wr_en pulse; done=1, dsp_reset=0.
- Oversize count: start, stream 08 01 -> ERR right after the second byte; in_ready=0 afterwards; no writes occur.
- Gapped valid and reset: toggle in_valid every other cycle during the nominal frame -> identical writes and DONE. Separately, assert reset after the byte 12 -> all outputs return to reset values asynchronously and the state is IDLE.
- Max frame: N=0x0800, words equal to their index -> last write at addr 0xFFE with data 0x07FF; done=1; start pulsed mid-load has no effect.
